// File: rtl/varredura_sonar.sv
// Sweep sequencer: ping-pongs the servo position, fires one HC-SR04 measurement
// per position and reports every sample plus the nearest object of each sweep.
//
// state    | meaning
// INICIAL  | idle, waiting for ligar
// PREPARA  | restart at position 0, direction up, clear running minimum
// ASSENTA  | servo settling (T_ASSENTAR cycles)
// DISPARA  | request one measurement
// ESPERA   | waiting for pronto, bounded by T_TIMEOUT cycles
// REGISTRA | valid sample published, running minimum updated
// TIMEOUT  | timed-out sample published
// PROXIMA  | advance position (turnaround at the ends) or stop
module varredura_sonar #(
  parameter int N_POS      = 8,
  parameter int POS_W      = 3,
  parameter int T_ASSENTAR = 25000000,
  parameter int T_TIMEOUT  = 3000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ligar,
  input  logic             pronto,
  input  logic [11:0]      medida,
  output logic             medir,
  output logic [POS_W-1:0] posicao,
  output logic             dado_valido,
  output logic [POS_W-1:0] dado_posicao,
  output logic [11:0]      dado_medida,
  output logic             dado_erro,
  output logic [11:0]      menor_medida,
  output logic [POS_W-1:0] menor_posicao,
  output logic             fim_varredura,
  output logic [3:0]       db_estado
);

  localparam int T_MAX = (T_ASSENTAR > T_TIMEOUT) ? T_ASSENTAR : T_TIMEOUT;
  localparam int TMR_W = $clog2(T_MAX + 1);

  localparam logic [TMR_W-1:0] TC_ASSENTAR = TMR_W'(T_ASSENTAR - 1);
  localparam logic [TMR_W-1:0] TC_TIMEOUT  = TMR_W'(T_TIMEOUT - 1);
  localparam logic [POS_W-1:0] POS_ULTIMA  = POS_W'(N_POS - 1);
  localparam logic [POS_W-1:0] POS_PENULT  = POS_W'(N_POS - 2);
  localparam logic [11:0]      BCD_MAX     = 12'h999;

  typedef enum logic [2:0] {
    INICIAL  = 3'd0,
    PREPARA  = 3'd1,
    ASSENTA  = 3'd2,
    DISPARA  = 3'd3,
    ESPERA   = 3'd4,
    REGISTRA = 3'd5,
    TIMEOUT  = 3'd6,
    PROXIMA  = 3'd7
  } estado_t;

  estado_t          estado;
  logic [TMR_W-1:0] tmr;
  logic             subindo;
  logic [11:0]      min_medida;
  logic [POS_W-1:0] min_posicao;

  assign db_estado = {1'b0, estado};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado        <= INICIAL;
      tmr           <= '0;
      subindo       <= 1'b1;
      min_medida    <= BCD_MAX;
      min_posicao   <= '0;
      medir         <= 1'b0;
      posicao       <= '0;
      dado_valido   <= 1'b0;
      dado_posicao  <= '0;
      dado_medida   <= '0;
      dado_erro     <= 1'b0;
      menor_medida  <= BCD_MAX;
      menor_posicao <= '0;
      fim_varredura <= 1'b0;
    end else begin
      medir         <= 1'b0;
      dado_valido   <= 1'b0;
      fim_varredura <= 1'b0;
      case (estado)
        INICIAL: begin
          if (ligar) estado <= PREPARA;
        end
        PREPARA: begin
          posicao     <= '0;
          subindo     <= 1'b1;
          min_medida  <= BCD_MAX;
          min_posicao <= '0;
          tmr         <= TC_ASSENTAR;
          estado      <= ASSENTA;
        end
        ASSENTA: begin
          if (tmr == '0) estado <= DISPARA;
          else           tmr    <= tmr - TMR_W'(1);
        end
        DISPARA: begin
          medir  <= 1'b1;
          tmr    <= TC_TIMEOUT;
          estado <= ESPERA;
        end
        // medida is only valid in the pronto cycle, so it is latched here
        ESPERA: begin
          if (pronto) begin
            dado_medida  <= medida;
            dado_posicao <= posicao;
            dado_erro    <= 1'b0;
            dado_valido  <= 1'b1;
            estado       <= REGISTRA;
          end else if (tmr == '0) begin
            dado_medida  <= 12'hFFF;
            dado_posicao <= posicao;
            dado_erro    <= 1'b1;
            dado_valido  <= 1'b1;
            estado       <= TIMEOUT;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        REGISTRA: begin
          if (dado_medida < min_medida) begin
            min_medida  <= dado_medida;
            min_posicao <= dado_posicao;
          end
          estado <= PROXIMA;
        end
        TIMEOUT: begin
          estado <= PROXIMA;
        end
        PROXIMA: begin
          if (!ligar) begin
            estado <= INICIAL;
          end else begin
            tmr    <= TC_ASSENTAR;
            estado <= ASSENTA;
            if ((subindo && posicao == POS_ULTIMA) || (!subindo && posicao == '0)) begin
              fim_varredura <= 1'b1;
              menor_medida  <= min_medida;
              menor_posicao <= min_posicao;
              min_medida    <= BCD_MAX;
              min_posicao   <= '0;
              subindo       <= !subindo;
              posicao       <= subindo ? POS_PENULT : POS_W'(1);
            end else begin
              posicao <= subindo ? posicao + POS_W'(1) : posicao - POS_W'(1);
            end
          end
        end
        default: estado <= INICIAL;
      endcase
    end
  end

endmodule

// File: tb/tb_varredura_sonar.sv
// Randomized bench for varredura_sonar: an agent answers medir and checks every
// sample, turnaround and timing against a sample-index model of the sweep.
module tb_varredura_sonar;

  localparam int N_POS      = 4;
  localparam int POS_W      = 2;
  localparam int T_ASSENTAR = 10;
  localparam int T_TIMEOUT  = 50;
  localparam int PERIODO    = 2 * (N_POS - 1);

  logic             clock;
  logic             reset;
  logic             ligar;
  logic             pronto;
  logic [11:0]      medida;
  logic             medir;
  logic [POS_W-1:0] posicao;
  logic             dado_valido;
  logic [POS_W-1:0] dado_posicao;
  logic [11:0]      dado_medida;
  logic             dado_erro;
  logic [11:0]      menor_medida;
  logic [POS_W-1:0] menor_posicao;
  logic             fim_varredura;
  logic [3:0]       db_estado;

  varredura_sonar #(
    .N_POS(N_POS), .POS_W(POS_W), .T_ASSENTAR(T_ASSENTAR), .T_TIMEOUT(T_TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .pronto(pronto), .medida(medida),
    .medir(medir), .posicao(posicao), .dado_valido(dado_valido),
    .dado_posicao(dado_posicao), .dado_medida(dado_medida), .dado_erro(dado_erro),
    .menor_medida(menor_medida), .menor_posicao(menor_posicao),
    .fim_varredura(fim_varredura), .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_medir"}, medir, 0);
    chk({tag, "_posicao"}, posicao, 0);
    chk({tag, "_valido"}, dado_valido, 0);
    chk({tag, "_dposicao"}, dado_posicao, 0);
    chk({tag, "_dmedida"}, dado_medida, 0);
    chk({tag, "_derro"}, dado_erro, 0);
    chk({tag, "_menor"}, menor_medida, 12'h999);
    chk({tag, "_menor_pos"}, menor_posicao, 0);
    chk({tag, "_fim"}, fim_varredura, 0);
    chk({tag, "_estado"}, db_estado, 0);
  endtask

  // sample k after a restart sits at a triangle wave of period 2*(N_POS-1)
  function automatic int pos_of(input int idx);
    int m;
    m = idx % PERIODO;
    return (m < N_POS) ? m : PERIODO - m;
  endfunction

  function automatic bit is_turn(input int idx);
    int m;
    m = idx % PERIODO;
    return (m == N_POS - 1) || (m == 0 && idx > 0);
  endfunction

  function automatic logic [11:0] rand_bcd();
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  // directed first run: d = cycles from medir to the pronto-sampling edge, 0 = never
  int          plan_d [10] = '{6, 6, 6, 50, 0, 6, 6, 0, 0, 0};
  logic [11:0] plan_v [10] = '{12'h250, 12'h045, 12'h045, 12'h300, 12'h123,
                               12'h123, 12'h123, 12'h000, 12'h000, 12'h000};

  bit          plan_en, stray_en;
  int          cyc = 0;
  int          n_medir = 0, n_valid = 0, n_fim = 0;
  int          kmed, cur_idx, cur_d, medir_cyc, exp_medir_cyc, exp_fim_cyc;
  int          pend_cnt, pend_d;
  bit          outstanding, pend_on, timed_out;
  logic [11:0] cur_v, pend_v;
  int          q_pos[$];
  logic [11:0] q_val[$];
  bit          q_err[$];

  // agent: drives pronto/medida and checks outputs 1 time unit after each edge
  initial begin
    int          r, mp;
    logic [11:0] mv;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (reset) begin
        outstanding = 0; pend_on = 0; kmed = 0;
        exp_medir_cyc = 0; exp_fim_cyc = 0;
        q_pos.delete(); q_val.delete(); q_err.delete();
        pronto = 1'b0;
      end else begin
        pronto = 1'b0;
        medida = 12'($urandom);
        if (db_estado == 4'd1) begin
          kmed = 0; exp_fim_cyc = 0;
          q_pos.delete(); q_val.delete(); q_err.delete();
          exp_medir_cyc = cyc + T_ASSENTAR + 2;
        end
        if (medir) begin
          n_medir++;
          chk("medir_dup", outstanding, 0);
          chk("medir_cyc", cyc, exp_medir_cyc);
          chk("posicao", posicao, pos_of(kmed));
          outstanding = 1; cur_idx = kmed; kmed++; medir_cyc = cyc;
          if (plan_en && cur_idx < 10) begin
            cur_d = plan_d[cur_idx]; cur_v = plan_v[cur_idx];
          end else begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      cur_d = 0;
            else if (r == 1) cur_d = T_TIMEOUT;
            else if (r == 2) cur_d = int'($urandom_range(T_TIMEOUT + 1, T_TIMEOUT + 3));
            else             cur_d = int'($urandom_range(1, T_TIMEOUT - 1));
            cur_v = rand_bcd();
          end
          pend_on = 1; pend_cnt = 0; pend_d = cur_d; pend_v = cur_v;
        end
        if (dado_valido) begin
          n_valid++;
          chk("valido_unexp", outstanding, 1);
          timed_out = (cur_d == 0) || (cur_d > T_TIMEOUT);
          chk("valido_cyc", cyc, medir_cyc + (timed_out ? T_TIMEOUT : cur_d));
          chk("dado_erro", dado_erro, timed_out);
          chk("dado_medida", dado_medida, timed_out ? 12'hFFF : cur_v);
          chk("dado_posicao", dado_posicao, pos_of(cur_idx));
          q_pos.push_back(pos_of(cur_idx)); q_val.push_back(cur_v); q_err.push_back(timed_out);
          outstanding = 0;
          if (cur_d == 0) pend_on = 0;
          exp_medir_cyc = cyc + T_ASSENTAR + 3;
          if (ligar && is_turn(cur_idx)) exp_fim_cyc = cyc + 2;
        end
        if (fim_varredura || (exp_fim_cyc != 0 && cyc == exp_fim_cyc)) begin
          if (fim_varredura) n_fim++;
          chk("fim_pulse", fim_varredura, 1);
          chk("fim_cyc", cyc, exp_fim_cyc);
          mv = 12'h999; mp = 0;
          foreach (q_val[i])
            if (!q_err[i] && q_val[i] < mv) begin mv = q_val[i]; mp = q_pos[i]; end
          chk("menor_medida", menor_medida, mv);
          chk("menor_posicao", menor_posicao, mp);
          q_pos.delete(); q_val.delete(); q_err.delete();
          exp_fim_cyc = 0;
        end
        if (pend_on) begin
          if (pend_d != 0 && pend_cnt == pend_d - 1) begin
            pronto = 1'b1; medida = pend_v; pend_on = 0;
          end else begin
            pend_cnt++;
          end
        end else if (stray_en && !outstanding && $urandom_range(0, 7) == 0) begin
          pronto = 1'b1;
        end
      end
    end
  end

  task automatic wait_valid(input int target, input int bound);
    for (int i = 0; i < bound && n_valid < target; i++) @(negedge clock);
    chk("wait_valido", n_valid, target);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int m0, v0;
    reset = 1'b1; ligar = 1'b0; pronto = 1'b0; medida = '0;
    plan_en = 1; stray_en = 0;
    repeat (3) @(posedge clock);
    #1 chk_reset_vals("rst_ini");
    @(negedge clock) reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("idle_estado", db_estado, 0);

    // directed sweeps: tie, timeout, coincident pronto, all-timeout sweep
    ligar = 1'b1;
    wait_valid(10, 2000);
    repeat (4) @(negedge clock);
    chk("n_fim_a", n_fim, 3);
    chk("menor_all_to", menor_medida, 12'h999);
    chk("menor_pos_all_to", menor_posicao, 0);

    // random responses with stray pronto between measurements
    plan_en = 0; stray_en = 1;
    wait_valid(50, 8000);
    chk("n_fim_b", n_fim, 16);

    // drop ligar while waiting at position 1
    for (int i = 0; i < 1000 && !(medir && posicao == 1); i++) @(negedge clock);
    chk("seen_pos1", medir && posicao == 1, 1);
    ligar = 1'b0; m0 = n_medir; v0 = n_valid;
    wait_valid(v0 + 1, 100);
    repeat (40) @(negedge clock);
    chk("stop_estado", db_estado, 0);
    chk("stop_posicao", posicao, 1);
    chk("stop_medir", n_medir, m0);
    chk("stop_valido", n_valid, v0 + 1);

    // reset during ASSENTA at position 1
    ligar = 1'b1; v0 = n_valid;
    wait_valid(v0 + 1, 200);
    for (int i = 0; i < 100 && db_estado != 4'd2; i++) @(negedge clock);
    chk("in_assenta", db_estado, 2);
    repeat (3) @(posedge clock);
    #3 reset = 1'b1; ligar = 1'b0;
    #1 chk_reset_vals("rst_assenta");
    repeat (3) @(negedge clock);
    reset = 1'b0; m0 = n_medir;
    repeat (30) @(negedge clock);
    chk("rst_a_no_medir", n_medir, m0);
    chk("rst_a_idle", db_estado, 0);

    // reset during ESPERA
    ligar = 1'b1;
    for (int i = 0; i < 200 && n_medir == m0; i++) @(negedge clock);
    chk("medir_after_rst", n_medir, m0 + 1);
    chk("espera_estado", db_estado, 4);
    #3 reset = 1'b1; ligar = 1'b0;
    #1 chk_reset_vals("rst_espera");
    repeat (3) @(negedge clock);
    reset = 1'b0; m0 = n_medir; v0 = n_valid;
    repeat (80) @(negedge clock);
    chk("rst_e_no_medir", n_medir, m0);
    chk("rst_e_no_valido", n_valid, v0);
    chk("rst_e_idle", db_estado, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
